// File: rtl/dac_spi_pkg.sv
// Shared constants for the MCP4911 SPI transmitter: FSM encoding, frame layout
// and the helper that assembles a 16-bit write frame.
package dac_spi_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SHIFT   = 2'd1;
  localparam logic [1:0] ST_CS_HOLD = 2'd2;
  localparam logic [1:0] ST_LDAC    = 2'd3;

  localparam int CMD_BIT  = 15;
  localparam int BUF_BIT  = 14;
  localparam int GA_BIT   = 13;
  localparam int SHDN_BIT = 12;
  localparam int DATA_MSB = 11;
  localparam int DATA_LSB = 2;

  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic       buf_b,
    input logic       ga_n,
    input logic       shdn_n,
    input logic [9:0] sample
  );
    logic [FRAME_BITS-1:0] w;
    w                    = '0;
    w[CMD_BIT]           = 1'b0;
    w[BUF_BIT]           = buf_b;
    w[GA_BIT]            = ga_n;
    w[SHDN_BIT]          = shdn_n;
    w[DATA_MSB:DATA_LSB] = sample;
    return w;
  endfunction

endpackage

// File: rtl/dac_spi_tx_tick_gen.sv
// Half-period divider: counts 0..CLK_DIV-1 and flags the last count with a
// one-cycle tick; restart forces the count back to zero.
module spi_tick_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dac_spi_tx.sv
// MCP4911 SPI write-frame serialiser with LDAC strobe and a one-deep pending
// sample buffer that reports overwrites.
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter bit BUF     = 1'b0,
  parameter bit GA_N    = 1'b1,
  parameter bit SHDN_N  = 1'b1
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [9:0] data_in,
  input  logic       load,
  output logic       dac_cs_n,
  output logic       dac_sck,
  output logic       dac_sdi,
  output logic       dac_ld_n,
  output logic       busy,
  output logic       overrun
);

  logic [1:0]            state_q, state_d;
  logic [4:0]            half_q, half_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [9:0]            pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sck_q, sck_d;
  logic                  sdi_q, sdi_d;
  logic                  ld_n_q, ld_n_d;
  logic                  busy_q, busy_d;
  logic                  ovr_q, ovr_d;

  logic                  tick;
  logic                  restart;
  logic                  start;
  logic                  decide;
  logic [9:0]            start_sample;
  logic [FRAME_BITS-1:0] start_word;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (sysclk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  // Frame-end decision happens on the edge that closes the LDAC half-period.
  assign decide     = (state_q == ST_LDAC) && tick;
  assign start_word = build_frame(BUF, GA_N, SHDN_N, start_sample);

  always_comb begin
    state_d      = state_q;
    half_d       = half_q;
    sr_d         = sr_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    cs_n_d       = cs_n_q;
    sck_d        = sck_q;
    sdi_d        = sdi_q;
    ld_n_d       = ld_n_q;
    busy_d       = busy_q;
    ovr_d        = 1'b0;
    restart      = 1'b0;
    start        = 1'b0;
    start_sample = data_in;

    case (state_q)
      ST_IDLE: begin
        restart = 1'b1;
        start   = load;
      end
      ST_SHIFT: begin
        if (tick) begin
          if (half_q == 5'd31) begin
            state_d = ST_CS_HOLD;
            cs_n_d  = 1'b1;
            sck_d   = 1'b0;
            sdi_d   = 1'b0;
          end else begin
            half_d = half_q + 5'd1;
            sck_d  = ~half_q[0];
            // Next bit goes out only when SCK drops, i.e. entering an even half-period.
            if (half_q[0]) begin
              sr_d  = {sr_q[FRAME_BITS-2:0], 1'b0};
              sdi_d = sr_q[FRAME_BITS-2];
            end
          end
        end
      end
      ST_CS_HOLD: begin
        if (tick) begin
          state_d = ST_LDAC;
          ld_n_d  = 1'b0;
        end
      end
      default: begin
        if (tick) begin
          ld_n_d = 1'b1;
          if (load) begin
            start      = 1'b1;
            ovr_d      = pend_vld_q;
            pend_vld_d = 1'b0;
          end else if (pend_vld_q) begin
            start        = 1'b1;
            start_sample = pend_q;
            pend_vld_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
    endcase

    if (busy_q && load && !decide) begin
      pend_d     = data_in;
      pend_vld_d = 1'b1;
      ovr_d      = pend_vld_q;
    end

    if (start) begin
      state_d = ST_SHIFT;
      half_d  = '0;
      sr_d    = start_word;
      sdi_d   = start_word[FRAME_BITS-1];
      cs_n_d  = 1'b0;
      sck_d   = 1'b0;
      busy_d  = 1'b1;
      restart = 1'b1;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      half_q     <= '0;
      sr_q       <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cs_n_q     <= 1'b1;
      sck_q      <= 1'b0;
      sdi_q      <= 1'b0;
      ld_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      sr_q       <= sr_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cs_n_q     <= cs_n_d;
      sck_q      <= sck_d;
      sdi_q      <= sdi_d;
      ld_n_q     <= ld_n_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
    end
  end

  assign dac_cs_n = cs_n_q;
  assign dac_sck  = sck_q;
  assign dac_sdi  = sdi_q;
  assign dac_ld_n = ld_n_q;
  assign busy     = busy_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: decodes SPI frames on SCK rising edges and
// checks frame contents, CS/LDAC/busy timing, pending and overrun behaviour.
module tb_dac_spi_tx;

  logic       sysclk;
  logic       rst_n;
  logic [9:0] data_a, data_b;
  logic       load_a, load_b;
  logic       cs_n_a, sck_a, sdi_a, ld_n_a, busy_a, ovr_a;
  logic       cs_n_b, sck_b, sdi_b, ld_n_b, busy_b, ovr_b;

  int n_checks = 0;
  int n_pass   = 0;
  int t_now    = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] sh_a, sh_b;
  int          cnt_a, cnt_b;
  int          ovr_cnt_a = 0;
  logic [15:0] fr;

  dac_spi_tx #(.CLK_DIV(2)) dut_a (
    .sysclk(sysclk), .rst_n(rst_n), .data_in(data_a), .load(load_a),
    .dac_cs_n(cs_n_a), .dac_sck(sck_a), .dac_sdi(sdi_a), .dac_ld_n(ld_n_a),
    .busy(busy_a), .overrun(ovr_a)
  );

  dac_spi_tx #(.CLK_DIV(2), .BUF(1'b1), .GA_N(1'b0), .SHDN_N(1'b0)) dut_b (
    .sysclk(sysclk), .rst_n(rst_n), .data_in(data_b), .load(load_b),
    .dac_cs_n(cs_n_b), .dac_sck(sck_b), .dac_sdi(sdi_b), .dac_ld_n(ld_n_b),
    .busy(busy_b), .overrun(ovr_b)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // SPI receivers: CS high discards any partial frame.
  always @(posedge sck_a or posedge cs_n_a) begin
    if (cs_n_a) cnt_a <= 0;
    else begin
      sh_a <= {sh_a[14:0], sdi_a};
      if (cnt_a == 15) begin
        qa.push_back({sh_a[14:0], sdi_a});
        cnt_a <= 0;
      end else cnt_a <= cnt_a + 1;
    end
  end

  always @(posedge sck_b or posedge cs_n_b) begin
    if (cs_n_b) cnt_b <= 0;
    else begin
      sh_b <= {sh_b[14:0], sdi_b};
      if (cnt_b == 15) begin
        qb.push_back({sh_b[14:0], sdi_b});
        cnt_b <= 0;
      end else cnt_b <= cnt_b + 1;
    end
  end

  always @(posedge sysclk) if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to 1 ns after edge t of the current frame (edge 0 = load accepted).
  task automatic to(input int t);
    if (t > t_now) begin
      repeat (t - t_now) @(posedge sysclk);
      #1;
      t_now = t;
    end
  endtask

  task automatic start_a(input logic [9:0] d);
    data_a = d;
    load_a = 1'b1;
    @(posedge sysclk);
    #1;
    load_a = 1'b0;
    t_now  = 0;
  endtask

  task automatic load_at_a(input int t, input logic [9:0] d);
    to(t - 1);
    data_a = d;
    load_a = 1'b1;
    to(t);
    load_a = 1'b0;
  endtask

  function automatic logic [15:0] pop_a();
    if (qa.size() == 0) return 16'hxxxx;
    return qa.pop_front();
  endfunction

  initial begin
    rst_n  = 1'b0;
    load_a = 1'b0;
    load_b = 1'b0;
    data_a = '0;
    data_b = '0;
    repeat (2) @(posedge sysclk);
    #1;
    chk("rst_outputs", {10'd0, cs_n_a, sck_a, sdi_a, ld_n_a, busy_a, ovr_a}, 16'b0000000000100100);
    rst_n = 1'b1;
    repeat (2) @(posedge sysclk);
    #1;
    chk("idle_hold", {12'd0, cs_n_a, sck_a, ld_n_a, busy_a}, 16'b1010);

    // Single frame, 10'h2AA
    start_a(10'h2AA);
    chk("f1_start", {12'd0, busy_a, cs_n_a, sck_a, sdi_a}, 16'b1000);
    to(1);  chk("f1_sck_t1", {15'd0, sck_a}, 16'd0);
    to(2);  chk("f1_sck_t2", {15'd0, sck_a}, 16'd1);
    to(63); chk("f1_cs_t63", {15'd0, cs_n_a}, 16'd0);
    to(64); chk("f1_cs_t64", {14'd0, cs_n_a, sck_a}, 16'b10);
    to(65); chk("f1_ld_t65", {15'd0, ld_n_a}, 16'd1);
    to(66); chk("f1_ld_t66", {15'd0, ld_n_a}, 16'd0);
    to(67); chk("f1_ld_t67", {14'd0, ld_n_a, busy_a}, 16'b01);
    to(68); chk("f1_end_t68", {14'd0, ld_n_a, busy_a}, 16'b10);
    chk("f1_frame", pop_a(), 16'h3AA8);

    // Config bits on the second instance
    data_b = 10'h3FF;
    load_b = 1'b1;
    @(posedge sysclk);
    #1;
    load_b = 1'b0;
    repeat (70) @(posedge sysclk);
    #1;
    chk("cfg_busy", {15'd0, busy_b}, 16'd0);
    chk("cfg_frame", (qb.size() > 0) ? qb.pop_front() : 16'hxxxx, 16'h4FFC);

    // Pending sample, no overrun
    ovr_cnt_a = 0;
    start_a(10'h001);
    load_at_a(10, 10'h002);
    to(67); chk("pend_cs_t67", {15'd0, cs_n_a}, 16'd1);
    to(68); chk("pend_t68", {14'd0, busy_a, cs_n_a}, 16'b10);
    to(136); chk("pend_idle", {15'd0, busy_a}, 16'd0);
    chk("pend_frame1", pop_a(), 16'h3004);
    chk("pend_frame2", pop_a(), 16'h3008);
    chk("pend_no_ovr", 16'(ovr_cnt_a), 16'd0);

    // Overrun
    ovr_cnt_a = 0;
    start_a(10'h001);
    load_at_a(10, 10'h002);
    chk("ovr_t10", {15'd0, ovr_a}, 16'd0);
    load_at_a(20, 10'h003);
    chk("ovr_t20", {15'd0, ovr_a}, 16'd1);
    to(21); chk("ovr_t21", {15'd0, ovr_a}, 16'd0);
    to(136); chk("ovr_idle", {15'd0, busy_a}, 16'd0);
    chk("ovr_frame1", pop_a(), 16'h3004);
    chk("ovr_frame2", pop_a(), 16'h300C);
    chk("ovr_count", 16'(ovr_cnt_a), 16'd1);

    // Load on the LDAC-ending edge with a pending sample
    ovr_cnt_a = 0;
    start_a(10'h001);
    load_at_a(10, 10'h002);
    load_at_a(68, 10'h005);
    chk("sim_t68", {13'd0, ovr_a, busy_a, cs_n_a}, 16'b110);
    to(69); chk("sim_ovr_t69", {15'd0, ovr_a}, 16'd0);
    to(136); chk("sim_idle", {15'd0, busy_a}, 16'd0);
    chk("sim_frame1", pop_a(), 16'h3004);
    chk("sim_frame2", pop_a(), 16'h3014);
    chk("sim_no_extra", 16'(qa.size()), 16'd0);

    // Asynchronous reset mid-frame
    start_a(10'h2AA);
    to(30);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {10'd0, cs_n_a, sck_a, sdi_a, ld_n_a, busy_a, ovr_a}, 16'b100100);
    repeat (2) @(posedge sysclk);
    #1;
    rst_n = 1'b1;
    qa.delete();
    @(posedge sysclk);
    #1;
    start_a(10'h155);
    to(70); chk("rst_after_idle", {15'd0, busy_a}, 16'd0);
    chk("rst_frame", pop_a(), 16'h3554);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
